// File: rtl/regfile.sv
// Four-entry register file: two combinational read ports, one synchronous write port, debug taps.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module regfile #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            r_read1,
  input  logic [1:0]            r_read2,
  input  logic [1:0]            r_write,
  input  logic [DATA_WIDTH-1:0] r_write_data,
  input  logic                  write,
  output logic [DATA_WIDTH-1:0] r_read1_data,
  output logic [DATA_WIDTH-1:0] r_read2_data,
  output logic [DATA_WIDTH-1:0] reg0data,
  output logic [DATA_WIDTH-1:0] reg1data,
  output logic [DATA_WIDTH-1:0] reg2data,
  output logic [DATA_WIDTH-1:0] reg3data
);

  logic [DATA_WIDTH-1:0] r_regs [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else if (write) begin
      r_regs[r_write] <= r_write_data;
    end
  end

  logic [DATA_WIDTH-1:0] w_rd1;
  logic [DATA_WIDTH-1:0] w_rd2;

  assign w_rd1 = r_regs[r_read1];
  assign w_rd2 = r_regs[r_read2];

`ifdef REGFILE_BYPASS_EN
  logic w_fwd1;
  logic w_fwd2;

  // Forwarding is held off during reset so every output reads zero there.
  assign w_fwd1 = rst_n && write && (r_read1 == r_write);
  assign w_fwd2 = rst_n && write && (r_read2 == r_write);

  assign r_read1_data = w_fwd1 ? r_write_data : w_rd1;
  assign r_read2_data = w_fwd2 ? r_write_data : w_rd2;
`else
  assign r_read1_data = w_rd1;
  assign r_read2_data = w_rd2;
`endif

  assign reg0data = r_regs[0];
  assign reg1data = r_regs[1];
  assign reg2data = r_regs[2];
  assign reg3data = r_regs[3];

endmodule

// File: tb/tb_regfile.sv
// Bench for regfile: directed plan steps then random traffic
// against an array model, including asynchronous reset pulses.
module tb_regfile;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    r_read1, r_read2, r_write;
  logic [DW-1:0] r_write_data;
  logic          write;
  logic [DW-1:0] r_read1_data, r_read2_data;
  logic [DW-1:0] reg0data, reg1data, reg2data, reg3data;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] mdl [4];

  regfile #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .r_read1(r_read1), .r_read2(r_read2),
    .r_write(r_write), .r_write_data(r_write_data),
    .write(write),
    .r_read1_data(r_read1_data), .r_read2_data(r_read2_data),
    .reg0data(reg0data), .reg1data(reg1data),
    .reg2data(reg2data), .reg3data(reg3data)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_rd(input logic [1:0] idx);
    if (!rst_n) return '0;
`ifdef REGFILE_BYPASS_EN
    if (write && idx == r_write) return r_write_data;
`endif
    return mdl[idx];
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":reg0"}, reg0data, mdl[0]);
    chk({tag, ":reg1"}, reg1data, mdl[1]);
    chk({tag, ":reg2"}, reg2data, mdl[2]);
    chk({tag, ":reg3"}, reg3data, mdl[3]);
    chk({tag, ":rd1"}, r_read1_data, exp_rd(r_read1));
    chk({tag, ":rd2"}, r_read2_data, exp_rd(r_read2));
  endtask

  // Drive while clk is low, check before and after the rising edge.
  task automatic cycle(input string tag, input logic we, input logic [1:0] wa,
                       input logic [DW-1:0] wd, input logic [1:0] a1,
                       input logic [1:0] a2);
    @(negedge clk);
    write = we; r_write = wa; r_write_data = wd;
    r_read1 = a1; r_read2 = a2;
    #1 check_all({tag, ":pre"});
    @(posedge clk);
    if (rst_n && write) mdl[r_write] = r_write_data;
    #1 check_all({tag, ":post"});
  endtask

  task automatic reset_pulse(input string tag);
    @(negedge clk);
    write = 1'b1; r_write_data = 8'hFF;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    #1 check_all({tag, ":async"});
    @(posedge clk);
    #1 check_all({tag, ":held"});
    @(negedge clk);
    rst_n = 1'b1;
    write = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    write = 1'b0; r_write = '0; r_write_data = '0;
    r_read1 = '0; r_read2 = '0;
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    #2 check_all("reset0");
    @(negedge clk);
    rst_n = 1'b1;

    cycle("wr0_a1", 1'b1, 2'd0, 8'hA1, 2'd0, 2'd1);
    chk("wr0_a1_lit", reg0data, 8'hA1);
    cycle("wr0_55", 1'b1, 2'd0, 8'h55, 2'd0, 2'd0);
    chk("wr0_55_lit", reg0data, 8'h55);
    cycle("sw1", 1'b1, 2'd1, 8'h55, 2'd1, 2'd0);
    cycle("sw2", 1'b1, 2'd2, 8'h55, 2'd2, 2'd0);
    cycle("sw3", 1'b1, 2'd3, 8'h55, 2'd3, 2'd0);
    cycle("sw0", 1'b1, 2'd0, 8'hE4, 2'd0, 2'd3);
    chk("sw0_lit", reg0data, 8'hE4);
    chk("sw3_lit", reg3data, 8'h55);
    cycle("wdis1", 1'b0, 2'd1, 8'h2D, 2'd1, 2'd2);
    cycle("wdis2", 1'b0, 2'd2, 8'h2D, 2'd2, 2'd1);
    chk("wdis_lit1", reg1data, 8'h55);
    chk("wdis_lit0", reg0data, 8'hE4);

    write = 1'b0;
    r_read1 = 2'd2;
    for (int i = 0; i < 4; i++) begin
      r_read2 = 2'(i);
      #1 check_all("rdsweep");
    end
    r_read1 = 2'd3;
    r_read2 = 2'd0;
    #1 chk("rd1_3_lit", r_read1_data, 8'h55);
    chk("rd2_0_lit", r_read2_data, 8'hE4);
    r_read2 = 2'd3;
    #1 chk("same_idx", r_read2_data, r_read1_data);

    // Same-register read during write: old value unless forwarding is built.
    @(negedge clk);
    write = 1'b1; r_write = 2'd2; r_write_data = 8'h3C;
    r_read1 = 2'd2; r_read2 = 2'd0;
`ifdef REGFILE_BYPASS_EN
    #1 chk("byp_rd1", r_read1_data, 8'h3C);
`else
    #1 chk("nobyp_rd1", r_read1_data, 8'h55);
`endif
    chk("byp_reg2_old", reg2data, 8'h55);
    @(posedge clk);
    mdl[2] = 8'h3C;
    #1 chk("byp_reg2_new", reg2data, 8'h3C);
    check_all("byp_post");

    reset_pulse("rst_mid");

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 29) == 0) reset_pulse("rnd_rst");
      cycle("rnd", 1'($urandom_range(0, 1)), 2'($urandom),
            8'($urandom), 2'($urandom), 2'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
